mips_fetch_sequencer: RTL and testbench
=======================================

Name: mips_fetch_sequencer

Overview:
Controller that sequences the PC/fetch stage and arbitrates its instruction-memory port between normal fetch and a program loader. It generates PC-enable, redirect and IF-register flush/stall controls from hazard and branch inputs. It drains the pipeline before handing the memory port to the loader, then restarts fetch from a programmed address. It sits beside the PC stage, driving the PC datapath's control and write-port inputs and the PC→Reg pipeline register's enable/flush.

Parameters:
ADDR_L, 64, instruction memory depth in words
ADDR_W, Util_Math_log2(ADDR_L), word-address width
DRAIN_CYCLES, 4, cycles fetch is held off before the loader is granted (pipeline depth after PC)
RESET_PC, 0, byte address fetch restarts at after reset

Ports:
ctrl  input  Data_Control_Control_T  bundle carrying clk and reset; one clock, reset synchronous active-high
hazardStall  input  1  load-use stall request from decode
branchTaken  input  1  branch/jump resolved taken this cycle
loadReq  input  1  loader requests ownership of imem
loadValid  input  1  loader word valid (handshake with loadReady)
loadAddr  input  ADDR_W  loader word address
loadData  input  32  loader word
loadDone  input  1  loader finished; restart fetch
startPc  input  32  fetch restart byte address after load
pcEnable  output  1  PC register advances
pcLoad  output  1  force PC := pcLoadValue
pcLoadValue  output  32  forced PC value
ifStall  output  1  hold PC→Reg pipeline register
ifFlush  output  1  insert bubble into PC→Reg register
imemWe  output  1  imem write strobe
imemWAddr  output  ADDR_W  imem write address
imemWData  output  32  imem write data
loadReady  output  1  loader may present a word
loadGrant  output  1  loader owns imem
state  output  2  current FSM state (debug)

Behaviour:
- States: RUN=0, DRAIN=1, LOAD=2, RESTART=3. Registered state plus a drain counter of width log2(DRAIN_CYCLES)+1.
- Reset (sync, wins over all inputs): state=RESTART, counter=0. All registered outputs are 0 except pcLoadValue=RESET_PC.
- RUN: pcEnable = !hazardStall. ifStall = hazardStall. ifFlush = branchTaken.
  - branchTaken with hazardStall: flush wins. ifFlush=1, ifStall=0, pcEnable=0.
  - loadReq sampled 1 → DRAIN next cycle, counter := DRAIN_CYCLES-1. The fetch in the current cycle still completes.
- DRAIN: pcEnable=0, ifFlush=1 every cycle, counter decrements. At counter==0 → LOAD. branchTaken and hazardStall are ignored. loadReq dropping during DRAIN → RESTART with pcLoadValue = RESET_PC.
- LOAD: loadGrant=1, loadReady=1, pcEnable=0, ifFlush=1.
  - imemWe = loadValid & loadReady, combinational pass-through of loadAddr/loadData. Zero added latency; one write per cycle.
  - loadDone → RESTART, capturing startPc into pcLoadValue.
  - loadDone together with loadValid: the word is written, then the state transitions.
- RESTART: exactly one cycle with pcLoad=1, pcEnable=1, ifFlush=1 → RUN.
- imemWe is 0 in every state except LOAD. The write address is truncated to ADDR_W bits; no wrap check.
- Reset asserted mid-LOAD: the write in that cycle is suppressed (imemWe=0) and the FSM goes to RESTART.

Decomposition:
- Shared package Mips/Type/FetchState.v holds:
  - state encodings RUN/DRAIN/LOAD/RESTART and the 2-bit state width macro;
  - a Mips_Pipeline_FetchCtl bundle type (pcEnable, pcLoad, pcLoadValue, ifStall, ifFlush) with pack/unpack modules, matching the existing pipeline bundle style.
- One sub-module, mips_fetch_drain_counter: loadable down-counter with a zero flag.

Test Plan:
- Reset held 2 cycles then released → cycle after release: pcLoad=1, pcLoadValue=0, ifFlush=1; next cycle state=RUN, pcEnable=1.
- RUN, hazardStall=1 for 2 cycles → pcEnable=0, ifStall=1 both cycles; on release pcEnable=1. Adding branchTaken=1 in the 2nd cycle → ifFlush=1, ifStall=0.
- loadReq=1 in RUN with DRAIN_CYCLES=4 → exactly 4 DRAIN cycles with ifFlush=1, then loadGrant=1 on cycle 5.
- In LOAD, write addr 3 data 0x2008000A, then addr 63 data 0xFFFFFFFF → imemWe pulses with matching imemWAddr/imemWData in the same cycle; loadValid=0 → imemWe=0.
- loadDone with startPc=0x10 → one RESTART cycle with pcLoad=1, pcLoadValue=0x10, then RUN. loadDone+loadValid in the same cycle → the final write is performed.
- Reset asserted mid-LOAD with loadValid=1 → imemWe=0 that cycle, next state RESTART, pcLoadValue=RESET_PC.

Source files
------------

// File: rtl/mips_fetch_sequencer_pkg.sv
// Shared types for the fetch sequencer: clock/reset bundle, FSM encoding
// and the bundle of PC-stage controls the sequencer drives.
package mips_fetch_sequencer_pkg;

  localparam int STATE_W = 2;

  typedef struct packed {
    logic clk;
    logic reset;
  } ctrl_t;

  typedef enum logic [STATE_W-1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    LOAD    = 2'd2,
    RESTART = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic        pc_enable;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        if_stall;
    logic        if_flush;
  } fetch_ctl_t;

endpackage

// File: rtl/mips_fetch_drain_counter.sv
// Loadable down-counter that saturates at zero and flags when it gets there.
module mips_fetch_drain_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mips_fetch_sequencer.sv
// Sequences the PC/fetch stage and hands the instruction-memory write port to
// a program loader after draining the pipeline, then restarts fetch.
module mips_fetch_sequencer
  import mips_fetch_sequencer_pkg::*;
#(
  parameter int          ADDR_L       = 64,
  parameter int          ADDR_W       = $clog2(ADDR_L),
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] RESET_PC     = 32'd0
) (
  input  ctrl_t              ctrl,
  input  logic               hazardStall,
  input  logic               branchTaken,
  input  logic               loadReq,
  input  logic               loadValid,
  input  logic [ADDR_W-1:0]  loadAddr,
  input  logic [31:0]        loadData,
  input  logic               loadDone,
  input  logic [31:0]        startPc,
  output logic               pcEnable,
  output logic               pcLoad,
  output logic [31:0]        pcLoadValue,
  output logic               ifStall,
  output logic               ifFlush,
  output logic               imemWe,
  output logic [ADDR_W-1:0]  imemWAddr,
  output logic [31:0]        imemWData,
  output logic               loadReady,
  output logic               loadGrant,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES) + 1;

  logic         clk;
  logic         reset;
  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  pc_value_q;
  logic [31:0]  pc_value_d;
  logic         cnt_load;
  logic         cnt_dec;
  logic         cnt_zero;
  logic         write_en;
  logic         ready;
  logic         grant;
  fetch_ctl_t   ctl;

  assign clk   = ctrl.clk;
  assign reset = ctrl.reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RESTART;
      pc_value_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_value_q <= pc_value_d;
    end
  end

  mips_fetch_drain_counter #(
    .W(CNT_W)
  ) u_drain_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (CNT_W'(DRAIN_CYCLES - 1)),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_comb begin
    state_d           = state_q;
    pc_value_d        = pc_value_q;
    cnt_load          = 1'b0;
    cnt_dec           = 1'b0;
    write_en          = 1'b0;
    ready             = 1'b0;
    grant             = 1'b0;
    ctl               = '0;
    ctl.pc_load_value = pc_value_q;

    case (state_q)
      RUN: begin
        // A taken branch flushes the IF register, overriding a load-use stall.
        ctl.pc_enable = !hazardStall;
        ctl.if_flush  = branchTaken;
        ctl.if_stall  = hazardStall && !branchTaken;
        if (loadReq) begin
          state_d  = DRAIN;
          cnt_load = 1'b1;
        end
      end
      DRAIN: begin
        ctl.if_flush = 1'b1;
        if (!loadReq) begin
          state_d    = RESTART;
          pc_value_d = RESET_PC;
        end else if (cnt_zero) begin
          state_d = LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      LOAD: begin
        grant        = 1'b1;
        ready        = 1'b1;
        ctl.if_flush = 1'b1;
        write_en     = loadValid;
        if (loadDone) begin
          state_d    = RESTART;
          pc_value_d = startPc;
        end
      end
      RESTART: begin
        ctl.pc_load   = 1'b1;
        ctl.pc_enable = 1'b1;
        ctl.if_flush  = 1'b1;
        state_d       = RUN;
      end
      default: state_d = RESTART;
    endcase

    // Reset silences every strobe, including a loader write already in flight.
    if (reset) begin
      ctl.pc_enable = 1'b0;
      ctl.pc_load   = 1'b0;
      ctl.if_stall  = 1'b0;
      ctl.if_flush  = 1'b0;
      write_en      = 1'b0;
      ready         = 1'b0;
      grant         = 1'b0;
    end
  end

  assign pcEnable    = ctl.pc_enable;
  assign pcLoad      = ctl.pc_load;
  assign pcLoadValue = ctl.pc_load_value;
  assign ifStall     = ctl.if_stall;
  assign ifFlush     = ctl.if_flush;
  assign imemWe      = write_en;
  assign imemWAddr   = loadAddr;
  assign imemWData   = loadData;
  assign loadReady   = ready;
  assign loadGrant   = grant;
  assign state       = state_q;

endmodule

// File: tb/tb_mips_fetch_sequencer.sv
// Scoreboard bench: a behavioural model queues expected outputs per cycle and
// a negedge monitor pops and compares them against the sequencer.
module tb_mips_fetch_sequencer;
  import mips_fetch_sequencer_pkg::*;

  localparam int          ADDR_L       = 64;
  localparam int          ADDR_W       = 6;
  localparam int          DRAIN_CYCLES = 4;
  localparam logic [31:0] RESET_PC     = 32'h0;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  ctrl_t             ctrl;
  logic              hazardStall = 1'b0;
  logic              branchTaken = 1'b0;
  logic              loadReq = 1'b0;
  logic              loadValid = 1'b0;
  logic [ADDR_W-1:0] loadAddr = '0;
  logic [31:0]       loadData = '0;
  logic              loadDone = 1'b0;
  logic [31:0]       startPc = '0;
  logic              pcEnable, pcLoad, ifStall, ifFlush, imemWe, loadReady, loadGrant;
  logic [31:0]       pcLoadValue, imemWData;
  logic [ADDR_W-1:0] imemWAddr;
  logic [1:0]        state;

  assign ctrl = {clk, rst};
  always #5 clk = ~clk;

  mips_fetch_sequencer #(
    .ADDR_L(ADDR_L), .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN_CYCLES), .RESET_PC(RESET_PC)
  ) dut (
    .ctrl(ctrl), .hazardStall(hazardStall), .branchTaken(branchTaken),
    .loadReq(loadReq), .loadValid(loadValid), .loadAddr(loadAddr), .loadData(loadData),
    .loadDone(loadDone), .startPc(startPc), .pcEnable(pcEnable), .pcLoad(pcLoad),
    .pcLoadValue(pcLoadValue), .ifStall(ifStall), .ifFlush(ifFlush), .imemWe(imemWe),
    .imemWAddr(imemWAddr), .imemWData(imemWData), .loadReady(loadReady),
    .loadGrant(loadGrant), .state(state)
  );

  typedef struct {
    bit          pc_enable, pc_load, if_stall, if_flush, we, ready, grant;
    logic [31:0] pcv;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          st;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Model: phase numbers follow the documented debug encoding (0 run, 1 drain, 2 load, 3 restart).
  int          m_phase = 0;
  int          m_drain_left = 0;
  logic [31:0] m_pc = '0;
  bit          m_valid = 1'b0;
  bit          want_load = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output("pcEnable", 32'(pcEnable), 32'(mon_e.pc_enable));
      check_output("pcLoad", 32'(pcLoad), 32'(mon_e.pc_load));
      check_output("pcLoadValue", pcLoadValue, mon_e.pcv);
      check_output("ifStall", 32'(ifStall), 32'(mon_e.if_stall));
      check_output("ifFlush", 32'(ifFlush), 32'(mon_e.if_flush));
      check_output("imemWe", 32'(imemWe), 32'(mon_e.we));
      check_output("loadReady", 32'(loadReady), 32'(mon_e.ready));
      check_output("loadGrant", 32'(loadGrant), 32'(mon_e.grant));
      check_output("state", 32'(state), mon_e.st);
      if (mon_e.we) begin
        check_output("imemWAddr", 32'(imemWAddr), mon_e.waddr);
        check_output("imemWData", imemWData, mon_e.wdata);
      end
    end
  end

  task automatic apply_stimulus(input bit r, input bit h, input bit b, input bit lq,
                                input bit lv, input logic [ADDR_W-1:0] la,
                                input logic [31:0] ld, input bit dn, input logic [31:0] sp);
    exp_t e;
    rst = r; hazardStall = h; branchTaken = b; loadReq = lq;
    loadValid = lv; loadAddr = la; loadData = ld; loadDone = dn; startPc = sp;
    e.pc_enable = 0; e.pc_load = 0; e.if_stall = 0; e.if_flush = 0;
    e.we = 0; e.ready = 0; e.grant = 0;
    e.pcv = m_pc; e.st = m_phase; e.waddr = 32'(la); e.wdata = ld;
    if (!r) begin
      case (m_phase)
        0: begin e.pc_enable = !h; e.if_flush = b; e.if_stall = h && !b; end
        1: e.if_flush = 1;
        2: begin e.grant = 1; e.ready = 1; e.if_flush = 1; e.we = lv; end
        default: begin e.pc_load = 1; e.pc_enable = 1; e.if_flush = 1; end
      endcase
    end
    if (m_valid) exp_q.push_back(e);
    @(posedge clk);
    if (r) begin
      m_phase = 3; m_pc = RESET_PC; m_drain_left = 0; m_valid = 1;
    end else begin
      case (m_phase)
        0: if (lq) begin m_phase = 1; m_drain_left = DRAIN_CYCLES; end
        1: begin
          if (!lq) begin
            m_phase = 3; m_pc = RESET_PC;
          end else begin
            m_drain_left--;
            if (m_drain_left == 0) m_phase = 2;
          end
        end
        2: if (dn) begin m_phase = 3; m_pc = sp; end
        default: m_phase = 0;
      endcase
    end
    #1;
  endtask

  task automatic run_cycle(input bit h, input bit b, input bit lq);
    apply_stimulus(0, h, b, lq, 0, '0, 32'h0, 0, 32'h0);
  endtask

  task automatic load_cycle(input bit lv, input logic [ADDR_W-1:0] la, input logic [31:0] ld,
                            input bit dn, input logic [31:0] sp);
    apply_stimulus(0, 0, 0, 1, lv, la, ld, dn, sp);
  endtask

  task automatic enter_load();
    run_cycle(0, 0, 1);
    for (int i = 0; i < DRAIN_CYCLES; i++) run_cycle(1, 1, 1);
  endtask

  initial begin
    apply_stimulus(1, 0, 0, 0, 0, '0, 32'h0, 0, 32'h0);
    apply_stimulus(1, 0, 0, 0, 0, '0, 32'h0, 0, 32'h0);
    run_cycle(0, 0, 0);
    run_cycle(0, 0, 0);

    run_cycle(1, 0, 0);
    run_cycle(1, 1, 0);
    run_cycle(0, 0, 0);
    run_cycle(0, 1, 0);

    enter_load();
    load_cycle(1, 6'd3, 32'h2008000A, 0, 32'h0);
    load_cycle(1, 6'd63, 32'hFFFFFFFF, 0, 32'h0);
    load_cycle(0, 6'd5, 32'hDEADBEEF, 0, 32'h0);
    load_cycle(1, 6'd7, 32'h12345678, 1, 32'h10);
    run_cycle(0, 0, 0);
    run_cycle(0, 0, 0);

    enter_load();
    load_cycle(1, 6'd9, 32'hCAFEF00D, 0, 32'h0);
    apply_stimulus(1, 0, 0, 1, 1, 6'd10, 32'hA5A5A5A5, 0, 32'h0);
    run_cycle(0, 0, 0);
    run_cycle(0, 0, 0);

    enter_load();
    load_cycle(0, 6'd0, 32'h0, 1, 32'h20);
    run_cycle(0, 0, 0);
    run_cycle(0, 0, 1);
    run_cycle(0, 0, 1);
    run_cycle(0, 0, 0);
    run_cycle(0, 0, 0);
    run_cycle(0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 14) == 0) want_load = !want_load;
      apply_stimulus($urandom_range(0, 79) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0,
                     want_load,
                     $urandom_range(0, 1) == 1,
                     ADDR_W'($urandom_range(0, ADDR_L - 1)),
                     $urandom(),
                     $urandom_range(0, 7) == 0,
                     $urandom() & 32'hFFFF_FFFC);
    end

    run_cycle(0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
